// File: rtl/dmem_arbiter.sv
// Purpose: shares the single data-memory port between the CPU load/store path
//          and the debug/loader port. Every access runs through the same
//          fixed-latency IDLE -> ISSUE -> WAIT -> RESP sequence.
// Latency: a request seen in IDLE in cycle 0 is acked in cycle 1+MEM_LAT.
//          Back-to-back accesses complete once every MEM_LAT+2 cycles.
// Backpressure: each requester holds req/we/addr/wdata until its ack.
//          cpu_stall freezes the PC in the meantime. The losing requester
//          simply waits, because requests are only sampled in IDLE.
//
// Ports:
//   clock, reset                          rising-edge clock; async active-low reset
//   cpu_req/we/addr/wdata -> cpu_ack      CPU port. cpu_rdata is valid during the
//                                         ack and holds until the next CPU load.
//   cpu_stall                             cpu_req & ~cpu_ack
//   dbg_req/we/addr/wdata -> dbg_ack      debug port, same protocol; dbg_rdata
//   mem_read/mem_write/mem_addr/mem_wdata memory request, strobes high for 1 cycle
//   mem_rdata                             read data, valid MEM_LAT cycles after issue
//
// Parameters: ADDR_W, DATA_W, MEM_LAT (legal range 1..15).
// Optional macro DMEM_ARB_FIXED_PRIO_EN: when defined, the CPU always wins a
//   simultaneous request (debug can starve). When undefined, simultaneous
//   requests alternate round-robin.

module dmem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  // Owner of the current (or most recent) access: 1 = DBG, 0 = CPU.
  // This doubles as last_grant for the round-robin decision.
  logic              last_dbg_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dbg_rdata_q;

  logic              any_req;
  logic              pick_dbg;
  logic              grant;
  logic              load_resp;

  assign any_req = cpu_req | dbg_req;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign pick_dbg = dbg_req & ~cpu_req;
`else
  // On a tie, grant the port that did not win last time.
  assign pick_dbg = dbg_req & (~cpu_req | ~last_dbg_q);
`endif

  // Next state and outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    cpu_ack   = 1'b0;
    dbg_ack   = 1'b0;
    load_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mem_read  = ~we_q;
        mem_write = we_q;
        cnt_d     = LAT_LOAD;
        state_d   = (MEM_LAT > 1) ? WAIT : RESP;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: begin
        cpu_ack   = ~last_dbg_q;
        dbg_ack   = last_dbg_q;
        load_resp = ~we_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_dbg_q  <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (grant) begin
        last_dbg_q <= pick_dbg;
        we_q       <= pick_dbg ? dbg_we    : cpu_we;
        addr_q     <= pick_dbg ? dbg_addr  : cpu_addr;
        wdata_q    <= pick_dbg ? dbg_wdata : cpu_wdata;
      end
      if (load_resp && !last_dbg_q) cpu_rdata_q <= mem_rdata;
      if (load_resp &&  last_dbg_q) dbg_rdata_q <= mem_rdata;
    end
  end

  // mem_rdata only becomes valid in the RESP cycle itself. It is therefore
  // forwarded during the ack and captured at the RESP edge so that it holds
  // afterwards.
  assign cpu_rdata = (load_resp && !last_dbg_q) ? mem_rdata : cpu_rdata_q;
  assign dbg_rdata = (load_resp &&  last_dbg_q) ? mem_rdata : dbg_rdata_q;

  // The latched request stays on the memory bus through WAIT and beyond.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Purpose: directed self-checking bench for dmem_arbiter. Three instances
//          (MEM_LAT = 1, 3, 4) share one set of inputs.
// Inputs change at the falling edge. Outputs are checked 1 time unit later,
// which lies within the same clock cycle.

module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int N  = 3;   // index 0: MEM_LAT=1, 1: MEM_LAT=3, 2: MEM_LAT=4

`ifdef DMEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic          cpu_req, cpu_we, dbg_req, dbg_we;
  logic [AW-1:0] cpu_addr, dbg_addr;
  logic [DW-1:0] cpu_wdata, dbg_wdata, mem_rdata;

  logic [N-1:0]  cpu_ack, cpu_stall, dbg_ack, mem_read, mem_write;
  logic [DW-1:0] cpu_rdata [N];
  logic [DW-1:0] dbg_rdata [N];
  logic [AW-1:0] mem_addr  [N];
  logic [DW-1:0] mem_wdata [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : (g == 1) ? 3 : 4;
    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) u_dut (
      .clock    (clock),
      .reset    (reset),
      .cpu_req  (cpu_req),
      .cpu_we   (cpu_we),
      .cpu_addr (cpu_addr),
      .cpu_wdata(cpu_wdata),
      .cpu_ack  (cpu_ack[g]),
      .cpu_rdata(cpu_rdata[g]),
      .cpu_stall(cpu_stall[g]),
      .dbg_req  (dbg_req),
      .dbg_we   (dbg_we),
      .dbg_addr (dbg_addr),
      .dbg_wdata(dbg_wdata),
      .dbg_ack  (dbg_ack[g]),
      .dbg_rdata(dbg_rdata[g]),
      .mem_read (mem_read[g]),
      .mem_write(mem_write[g]),
      .mem_addr (mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata)
    );
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wcount;
    bit exp_c, exp_d;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    mem_rdata = '0;

    // Reset values on every instance
    tick(); tick(); #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst_cpu_ack%0d", i), cpu_ack[i], 0);
      chk($sformatf("rst_dbg_ack%0d", i), dbg_ack[i], 0);
      chk($sformatf("rst_mem_read%0d", i), mem_read[i], 0);
      chk($sformatf("rst_mem_write%0d", i), mem_write[i], 0);
      chk($sformatf("rst_mem_addr%0d", i), mem_addr[i], 0);
      chk($sformatf("rst_mem_wdata%0d", i), mem_wdata[i], 0);
      chk($sformatf("rst_cpu_rdata%0d", i), cpu_rdata[i], 0);
      chk($sformatf("rst_dbg_rdata%0d", i), dbg_rdata[i], 0);
    end
    reset = 1'b1;

    // T1: CPU load 0x10, MEM_LAT=1
    tick(); cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; mem_rdata = 32'hDEADBEEF; #1;
    chk("t1_c0_stall", cpu_stall[0], 1);
    chk("t1_c0_read", mem_read[0], 0);
    tick(); #1;
    chk("t1_c1_stall", cpu_stall[0], 1);
    chk("t1_c1_read", mem_read[0], 1);
    chk("t1_c1_addr", mem_addr[0], 32'h10);
    chk("t1_c1_ack", cpu_ack[0], 0);
    tick(); #1;
    chk("t1_c2_ack", cpu_ack[0], 1);
    chk("t1_c2_rdata", cpu_rdata[0], 32'hDEADBEEF);
    chk("t1_c2_stall", cpu_stall[0], 0);
    tick(); cpu_req = 0; mem_rdata = 32'h0; #1;
    chk("t1_c3_ack", cpu_ack[0], 0);
    chk("t1_c3_rdata_hold", cpu_rdata[0], 32'hDEADBEEF);

    // T2: cpu_req dropped right after grant, MEM_LAT=3
    do_reset();
    tick(); cpu_req = 1; cpu_we = 0; cpu_addr = 32'h30; mem_rdata = 32'hA5A50003; #1;
    tick(); cpu_req = 0; #1;
    chk("drop_c1_read", mem_read[1], 1);
    chk("drop_c1_stall", cpu_stall[1], 0);
    chk("drop_c1_ack", cpu_ack[1], 0);
    for (int c = 2; c <= 6; c++) begin
      tick(); #1;
      chk($sformatf("drop_c%0d_ack", c), cpu_ack[1], (c == 4));
      if (c == 4) chk("drop_c4_rdata", cpu_rdata[1], 32'hA5A50003);
    end

    // T3: CPU store 0x20 <= 0x12345678, MEM_LAT=3, cpu_rdata must not change
    tick(); cpu_req = 1; cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'h12345678;
    mem_rdata = 32'hFFFF0000; #1;
    wcount = 0;
    chk("st_c0_write", mem_write[1], 0);
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 4) cpu_req = 0;
      #1;
      if (mem_write[1] === 1'b1) wcount++;
      if (c == 1) begin
        chk("st_c1_write", mem_write[1], 1);
        chk("st_c1_read", mem_read[1], 0);
        chk("st_c1_addr", mem_addr[1], 32'h20);
        chk("st_c1_wdata", mem_wdata[1], 32'h12345678);
      end
      chk($sformatf("st_c%0d_ack", c), cpu_ack[1], (c == 4));
      chk($sformatf("st_c%0d_rdata", c), cpu_rdata[1], 32'hA5A50003);
    end
    chk("st_write_pulses", wcount, 1);
    cpu_we = 0;

    // T4: both requests held continuously, MEM_LAT=1
    do_reset();
    tick(); cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100;
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h200; mem_rdata = 32'h5555AAAA; #1;
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) begin tick(); #1; end
      // Access k occupies cycles 3k..3k+2; round-robin alternates CPU/DBG
      exp_c = ((c % 3) == 2) && (FIXED || ((c / 3) % 2 == 0));
      exp_d = ((c % 3) == 2) && !FIXED && ((c / 3) % 2 == 1);
      chk($sformatf("rr_c%0d_cpu_ack", c), cpu_ack[0], exp_c);
      chk($sformatf("rr_c%0d_dbg_ack", c), dbg_ack[0], exp_d);
      if ((c % 3) == 1)
        chk($sformatf("rr_c%0d_addr", c), mem_addr[0],
            (FIXED || ((c / 3) % 2 == 0)) ? 32'h100 : 32'h200);
    end
    cpu_req = 0; dbg_req = 0;

    // T5: debug load, MEM_LAT=4, reset asserted in WAIT
    do_reset();
    tick(); dbg_req = 1; dbg_we = 0; dbg_addr = 32'h44; mem_rdata = 32'h0BADF00D; #1;
    tick(); #1;
    chk("rst5_c1_read", mem_read[2], 1);
    tick(); tick(); #1;
    chk("rst5_c3_addr", mem_addr[2], 32'h44);
    reset = 0; dbg_req = 0; #1;
    chk("rst5_dbg_ack", dbg_ack[2], 0);
    chk("rst5_cpu_ack", cpu_ack[2], 0);
    chk("rst5_read", mem_read[2], 0);
    chk("rst5_write", mem_write[2], 0);
    chk("rst5_addr", mem_addr[2], 0);
    chk("rst5_wdata", mem_wdata[2], 0);
    chk("rst5_dbg_rdata", dbg_rdata[2], 0);
    chk("rst5_cpu_stall", cpu_stall[2], 0);
    tick(); tick(); reset = 1;
    for (int c = 0; c < 5; c++) begin
      tick(); #1;
      chk($sformatf("rst5_idle%0d_ack", c), dbg_ack[2], 0);
    end
    tick(); dbg_req = 1; #1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 5) dbg_req = 0;
      #1;
      if (c == 1) chk("re_c1_addr", mem_addr[2], 32'h44);
      chk($sformatf("re_c%0d_ack", c), dbg_ack[2], (c == 5));
      if (c == 5) chk("re_c5_rdata", dbg_rdata[2], 32'h0BADF00D);
    end
    chk("re_rdata_hold", dbg_rdata[2], 32'h0BADF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
